// File: rtl/snp_req_handler_pkg.sv
// snp_req_handler_pkg: MESI state codes and snoop request/response codes
// shared by the snoop handler and its coherence decoder.
package snp_req_handler_pkg;

  // MESI line states as stored in the tag/state array
  localparam logic [2:0] INVALID   = 3'd0;
  localparam logic [2:0] SHARED    = 3'd1;
  localparam logic [2:0] EXCLUSIVE = 3'd2;
  localparam logic [2:0] MODIFIED  = 3'd3;

  // Snoop request opcodes (2'd3 is not a legal opcode)
  localparam logic [1:0] SUR_RD  = 2'd0;
  localparam logic [1:0] SUR_INV = 2'd1;
  localparam logic [1:0] SUR_RFO = 2'd2;

  // Snoop response codes
  localparam logic [1:0] SUT_OKAY = 2'd0;
  localparam logic [1:0] SUT_INV  = 2'd1;

  // Opcodes that need the dirty block when the line is MODIFIED
  function automatic logic is_fwd_op(input logic [1:0] op);
    return (op == SUR_RD) || (op == SUR_RFO);
  endfunction

endpackage

// File: rtl/snp_req_handler_fsm_snp_req_ctrl.sv
// fsm_snp_req_ctrl: pure MESI snoop decoder. Given the current line state
// and the snoop opcode it returns the next line state and the bus response.
module fsm_snp_req_ctrl
  import snp_req_handler_pkg::*;
(
  input  logic [2:0] cur_st,
  input  logic [1:0] snp_op,
  output logic [2:0] nxt_st,
  output logic [1:0] snp_rsp
);

  // Decode next state and response; an unknown opcode leaves the line untouched
  always_comb begin
    nxt_st  = cur_st;
    snp_rsp = SUT_OKAY;
    case (snp_op)
      SUR_RD: begin
        nxt_st  = SHARED;
        snp_rsp = (cur_st == INVALID) ? SUT_INV : SUT_OKAY;
      end
      SUR_INV: begin
        nxt_st  = INVALID;
        snp_rsp = SUT_INV;
      end
      SUR_RFO: begin
        nxt_st  = INVALID;
        snp_rsp = (cur_st == INVALID) ? SUT_INV : SUT_OKAY;
      end
      default: begin
        nxt_st  = cur_st;
        snp_rsp = SUT_OKAY;
      end
    endcase
  end

endmodule

// File: rtl/snp_req_handler.sv
// snp_req_handler: snoop-side request handler of a direct-mapped cache.
// Takes one snoop at a time, reads tag/state, updates the MESI state through
// fsm_snp_req_ctrl and returns a response. Define SNP_DATA_FWD_EN to also
// forward the dirty block on RD/RFO hits to a MODIFIED line.
module snp_req_handler
  import snp_req_handler_pkg::*;
#(
  parameter  int ADDR_W = 32,
  parameter  int IDX_W  = 6,
  parameter  int OFS_W  = 6,
  parameter  int BLK_W  = 512,
  localparam int TAG_W  = ADDR_W - IDX_W - OFS_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              snp_req_vld,
  output logic              snp_req_rdy,
  input  logic [1:0]        snp_req_op,
  input  logic [ADDR_W-1:0] snp_req_addr,
  output logic              snp_rsp_vld,
  input  logic              snp_rsp_rdy,
  output logic [1:0]        snp_rsp,
  output logic [BLK_W-1:0]  snp_rsp_dat,
  output logic              snp_rsp_dvld,
  output logic              tag_rd_en,
  output logic [IDX_W-1:0]  tag_rd_idx,
  input  logic [TAG_W-1:0]  tag_rd_tag,
  input  logic [2:0]        tag_rd_st,
  output logic              st_wr_en,
  output logic [IDX_W-1:0]  st_wr_idx,
  output logic [2:0]        st_wr_st,
  output logic              dat_rd_en,
  output logic [IDX_W-1:0]  dat_rd_idx,
  input  logic [BLK_W-1:0]  dat_rd_dat,
  input  logic              cpu_lock_vld,
  input  logic [IDX_W-1:0]  cpu_lock_idx,
  output logic              snp_lock_vld,
  output logic [IDX_W-1:0]  snp_lock_idx
);

  typedef enum logic [2:0] {IDLE, RD_TAG, UPD, RD_DAT, RSP} state_t;

  state_t            state, state_nxt;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        rsp_q;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              hit, fwd, lock_conflict;
  logic [2:0]        cur_st, nxt_st;
  logic [1:0]        dec_rsp;
  logic              unused_ofs;

  assign idx           = addr_q[OFS_W +: IDX_W];
  assign tag           = addr_q[ADDR_W-1 -: TAG_W];
  assign unused_ofs    = ^addr_q[OFS_W-1:0];
  assign hit           = (tag_rd_tag == tag) && (tag_rd_st != INVALID);
  assign cur_st        = hit ? tag_rd_st : INVALID;
  assign lock_conflict = cpu_lock_vld && (cpu_lock_idx == idx);

  fsm_snp_req_ctrl u_ctrl (
    .cur_st  (cur_st),
    .snp_op  (op_q),
    .nxt_st  (nxt_st),
    .snp_rsp (dec_rsp)
  );

`ifdef SNP_DATA_FWD_EN
  assign fwd = hit && (cur_st == MODIFIED) && is_fwd_op(op_q);
`else
  assign fwd = 1'b0;
`endif

  assign tag_rd_idx   = idx;
  assign st_wr_idx    = idx;
  assign st_wr_st     = nxt_st;
  assign dat_rd_idx   = idx;
  assign snp_lock_idx = idx;
  assign snp_rsp      = rsp_q;

  // Handler state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and strobes; the CPU lock is checked before the snoop claims the index
  always_comb begin
    state_nxt    = state;
    snp_req_rdy  = 1'b0;
    tag_rd_en    = 1'b0;
    st_wr_en     = 1'b0;
    dat_rd_en    = 1'b0;
    snp_rsp_vld  = 1'b0;
    snp_lock_vld = 1'b0;
    case (state)
      IDLE: begin
        snp_req_rdy = 1'b1;
        if (snp_req_vld) state_nxt = RD_TAG;
      end
      RD_TAG: begin
        if (!lock_conflict) begin
          tag_rd_en = 1'b1;
          state_nxt = UPD;
        end
      end
      UPD: begin
        snp_lock_vld = 1'b1;
        st_wr_en     = hit && (nxt_st != cur_st);
        if (fwd) begin
          dat_rd_en = 1'b1;
          state_nxt = RD_DAT;
        end else begin
          state_nxt = RSP;
        end
      end
      RD_DAT: begin
        snp_lock_vld = 1'b1;
        state_nxt    = RSP;
      end
      RSP: begin
        snp_lock_vld = 1'b1;
        snp_rsp_vld  = 1'b1;
        if (snp_rsp_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the request on acceptance and the decoder response in UPD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      addr_q <= '0;
      rsp_q  <= '0;
    end else begin
      if (state == IDLE && snp_req_vld) begin
        op_q   <= snp_req_op;
        addr_q <= snp_req_addr;
      end
      if (state == UPD) rsp_q <= dec_rsp;
    end
  end

`ifdef SNP_DATA_FWD_EN
  logic [BLK_W-1:0] dat_q;
  logic             dvld_q;

  // Hold the forwarded block from RD_DAT until the response handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dat_q  <= '0;
      dvld_q <= 1'b0;
    end else if (state == RD_DAT) begin
      dat_q  <= dat_rd_dat;
      dvld_q <= 1'b1;
    end else if (state == RSP && snp_rsp_rdy) begin
      dvld_q <= 1'b0;
    end
  end

  assign snp_rsp_dat  = dat_q;
  assign snp_rsp_dvld = dvld_q;
`else
  logic unused_dat;
  assign unused_dat   = ^dat_rd_dat;
  assign snp_rsp_dat  = '0;
  assign snp_rsp_dvld = 1'b0;
`endif

endmodule

// File: tb/tb_snp_req_handler.sv
// tb_snp_req_handler: randomized scoreboard bench for snp_req_handler.
// Behaves as the tag/state/data arrays and the bus; expected responses and
// state writes are queued at issue time and checked by a separate monitor.
module tb_snp_req_handler;
  import snp_req_handler_pkg::*;

  localparam int ADDR_W = 32;
  localparam int IDX_W  = 6;
  localparam int OFS_W  = 6;
  localparam int BLK_W  = 512;
  localparam int TAG_W  = ADDR_W - IDX_W - OFS_W;
  localparam int NSETS  = 64;
`ifdef SNP_DATA_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clk, rst_n;
  logic              snp_req_vld, snp_req_rdy;
  logic [1:0]        snp_req_op;
  logic [ADDR_W-1:0] snp_req_addr;
  logic              snp_rsp_vld, snp_rsp_rdy;
  logic [1:0]        snp_rsp;
  logic [BLK_W-1:0]  snp_rsp_dat;
  logic              snp_rsp_dvld;
  logic              tag_rd_en;
  logic [IDX_W-1:0]  tag_rd_idx;
  logic [TAG_W-1:0]  rd_tag;
  logic [2:0]        rd_st;
  logic              st_wr_en;
  logic [IDX_W-1:0]  st_wr_idx;
  logic [2:0]        st_wr_st;
  logic              dat_rd_en;
  logic [IDX_W-1:0]  dat_rd_idx;
  logic [BLK_W-1:0]  rd_dat;
  logic              cpu_lock_vld;
  logic [IDX_W-1:0]  cpu_lock_idx;
  logic              snp_lock_vld;
  logic [IDX_W-1:0]  snp_lock_idx;

  typedef struct {
    logic [1:0]       rsp;
    logic             dvld;
    logic [BLK_W-1:0] dat;
    logic [IDX_W-1:0] idx;
    int               lat;
  } exp_t;

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic [2:0]       st;
  } wr_t;

  exp_t exp_q[$];
  wr_t  wr_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   accept_cyc = 0;

  logic [TAG_W-1:0] tag_mem [NSETS];
  logic [2:0]       st_mem  [NSETS];
  logic [BLK_W-1:0] dat_mem [NSETS];
  logic             filled = 1'b0;
  logic             set_en;
  logic [IDX_W-1:0] set_idx;
  logic [TAG_W-1:0] set_tag;
  logic [2:0]       set_st;
  logic [BLK_W-1:0] set_dat;

  snp_req_handler #(
    .ADDR_W(ADDR_W), .IDX_W(IDX_W), .OFS_W(OFS_W), .BLK_W(BLK_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .snp_req_vld  (snp_req_vld),
    .snp_req_rdy  (snp_req_rdy),
    .snp_req_op   (snp_req_op),
    .snp_req_addr (snp_req_addr),
    .snp_rsp_vld  (snp_rsp_vld),
    .snp_rsp_rdy  (snp_rsp_rdy),
    .snp_rsp      (snp_rsp),
    .snp_rsp_dat  (snp_rsp_dat),
    .snp_rsp_dvld (snp_rsp_dvld),
    .tag_rd_en    (tag_rd_en),
    .tag_rd_idx   (tag_rd_idx),
    .tag_rd_tag   (rd_tag),
    .tag_rd_st    (rd_st),
    .st_wr_en     (st_wr_en),
    .st_wr_idx    (st_wr_idx),
    .st_wr_st     (st_wr_st),
    .dat_rd_en    (dat_rd_en),
    .dat_rd_idx   (dat_rd_idx),
    .dat_rd_dat   (rd_dat),
    .cpu_lock_vld (cpu_lock_vld),
    .cpu_lock_idx (cpu_lock_idx),
    .snp_lock_vld (snp_lock_vld),
    .snp_lock_idx (snp_lock_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Cache arrays: random fill once, bench preloads, DUT state writes, 1-cycle reads
  always @(posedge clk) begin
    if (!filled) begin
      for (int i = 0; i < NSETS; i++) begin
        tag_mem[i] <= TAG_W'($urandom);
        st_mem[i]  <= 3'($urandom_range(0, 3));
        for (int w = 0; w < BLK_W / 32; w++) dat_mem[i][w*32 +: 32] <= $urandom;
      end
      filled <= 1'b1;
    end else begin
      if (set_en) begin
        tag_mem[set_idx] <= set_tag;
        st_mem[set_idx]  <= set_st;
        dat_mem[set_idx] <= set_dat;
      end
      if (st_wr_en) st_mem[st_wr_idx] <= st_wr_st;
    end
    if (tag_rd_en) begin
      rd_tag <= tag_mem[tag_rd_idx];
      rd_st  <= st_mem[tag_rd_idx];
    end
    if (dat_rd_en) rd_dat <= dat_mem[dat_rd_idx];
  end

  task automatic checkOutput(input string name, input logic [BLK_W-1:0] act,
                             input logic [BLK_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic setLine(input logic [IDX_W-1:0] idx, input logic [TAG_W-1:0] tag,
                         input logic [2:0] st, input logic [BLK_W-1:0] dat);
    set_en  = 1'b1;
    set_idx = idx;
    set_tag = tag;
    set_st  = st;
    set_dat = dat;
    @(posedge clk);
    #1 set_en = 1'b0;
  endtask

  // Issue one snoop: queue what the MESI rules predict, then play the bus side
  task automatic applyStimulus(input logic [1:0] op, input logic [IDX_W-1:0] idx,
                               input logic [TAG_W-1:0] tag, input int lock_cyc,
                               input int wait_cyc);
    exp_t       e;
    wr_t        w;
    logic       present;
    logic [2:0] st, new_st;
    logic       found;
    st      = st_mem[idx];
    present = (tag_mem[idx] == tag) && (st != INVALID);
    new_st  = st;
    case (op)
      SUR_RD:  begin e.rsp = present ? SUT_OKAY : SUT_INV; new_st = SHARED;  end
      SUR_INV: begin e.rsp = SUT_INV;                      new_st = INVALID; end
      SUR_RFO: begin e.rsp = present ? SUT_OKAY : SUT_INV; new_st = INVALID; end
      default: e.rsp = SUT_OKAY;
    endcase
    e.dvld = FWD && present && (st == MODIFIED) && (op == SUR_RD || op == SUR_RFO);
    e.dat  = e.dvld ? dat_mem[idx] : '0;
    e.idx  = idx;
    e.lat  = 3 + lock_cyc + (e.dvld ? 1 : 0);
    exp_q.push_back(e);
    if (present && new_st != st) begin
      w.idx = idx;
      w.st  = new_st;
      wr_q.push_back(w);
    end

    snp_req_vld  = 1'b1;
    snp_req_op   = op;
    snp_req_addr = {tag, idx, 6'($urandom)};
    accept_cyc   = cyc;
    @(posedge clk);
    #1 snp_req_vld = 1'b0;
    if (lock_cyc > 0) begin
      cpu_lock_vld = 1'b1;
      cpu_lock_idx = idx;
      repeat (lock_cyc) @(posedge clk);
      #1 cpu_lock_vld = 1'b0;
    end else if ($urandom_range(0, 1) == 1) begin
      cpu_lock_vld = 1'b1;
      cpu_lock_idx = idx ^ 6'd1;
      @(posedge clk);
      #1 cpu_lock_vld = 1'b0;
    end

    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      found = snp_rsp_vld;
    end
    if (!found) begin
      n_cmp++;
      n_err++;
      $display("[TB] FAIL rsp_timeout: got no snp_rsp_vld, expected one within 40 cycles");
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    repeat (wait_cyc) @(posedge clk);
    #1 snp_rsp_rdy = 1'b1;
    @(posedge clk);
    #1 snp_rsp_rdy = 1'b0;
  endtask

  // Monitor: compares responses, state writes and lock fencing against the queues
  initial begin : monitor
    exp_t e;
    wr_t  w;
    logic vld_seen;
    logic hs_prev;
    vld_seen = 1'b0;
    hs_prev  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        vld_seen = 1'b0;
        hs_prev  = 1'b0;
        continue;
      end
      if (hs_prev) checkOutput("idle_after_hs", snp_req_rdy, 1'b1);
      hs_prev = 1'b0;
      if (st_wr_en) begin
        if (wr_q.size() == 0) checkOutput("unexpected_wr", st_wr_en, 1'b0);
        else begin
          w = wr_q.pop_front();
          checkOutput("wr_idx", st_wr_idx, w.idx);
          checkOutput("wr_st", st_wr_st, w.st);
        end
      end
      if (cpu_lock_vld && cpu_lock_idx == tag_rd_idx)
        checkOutput("lock_fence", tag_rd_en, 1'b0);
      if (snp_rsp_vld) begin
        if (exp_q.size() == 0) checkOutput("unexpected_rsp", snp_rsp_vld, 1'b0);
        else begin
          e = exp_q[0];
          if (!vld_seen) checkOutput("latency", cyc - accept_cyc, e.lat);
          vld_seen = 1'b1;
          checkOutput("req_rdy_busy", snp_req_rdy, 1'b0);
          checkOutput("rsp", snp_rsp, e.rsp);
          checkOutput("rsp_dvld", snp_rsp_dvld, e.dvld);
          if (e.dvld) checkOutput("rsp_dat", snp_rsp_dat, e.dat);
          checkOutput("snp_lock", {snp_lock_vld, snp_lock_idx}, {1'b1, e.idx});
          if (snp_rsp_rdy) begin
            void'(exp_q.pop_front());
            vld_seen = 1'b0;
            hs_prev  = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [1:0]       op;
    int               lock;
    rst_n        = 1'b0;
    snp_req_vld  = 1'b0;
    snp_req_op   = '0;
    snp_req_addr = '0;
    snp_rsp_rdy  = 1'b0;
    cpu_lock_vld = 1'b0;
    cpu_lock_idx = '0;
    set_en       = 1'b0;
    set_idx      = '0;
    set_tag      = '0;
    set_st       = '0;
    set_dat      = '0;

    @(negedge clk);
    checkOutput("rst_req_rdy", snp_req_rdy, 1'b1);
    checkOutput("rst_rsp_vld", snp_rsp_vld, 1'b0);
    checkOutput("rst_rsp", snp_rsp, SUT_OKAY);
    checkOutput("rst_dvld", snp_rsp_dvld, 1'b0);
    checkOutput("rst_strobes", {tag_rd_en, st_wr_en, dat_rd_en, snp_lock_vld}, 4'b0000);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed: miss, forwarding hit, RFO, shared read, invalidate, held response, lock stall, illegal op
    setLine(6'd3, 20'h01234, EXCLUSIVE, dat_mem[3]);
    applyStimulus(SUR_RD, 6'd3, 20'h04321, 0, 1);
    setLine(6'd5, 20'h00ABC, MODIFIED, {64{8'hA5}});
    applyStimulus(SUR_RD, 6'd5, 20'h00ABC, 0, 1);
    setLine(6'd7, 20'h00777, EXCLUSIVE, dat_mem[7]);
    applyStimulus(SUR_RFO, 6'd7, 20'h00777, 0, 2);
    setLine(6'd8, 20'h00888, SHARED, dat_mem[8]);
    applyStimulus(SUR_RD, 6'd8, 20'h00888, 0, 1);
    setLine(6'd9, 20'h00999, SHARED, dat_mem[9]);
    applyStimulus(SUR_INV, 6'd9, 20'h00999, 0, 1);
    setLine(6'd10, 20'h0AAAA, EXCLUSIVE, dat_mem[10]);
    applyStimulus(SUR_RD, 6'd10, 20'h0AAAA, 0, 5);
    setLine(6'd11, 20'h0BBBB, EXCLUSIVE, dat_mem[11]);
    applyStimulus(SUR_RFO, 6'd11, 20'h0BBBB, 4, 1);
    setLine(6'd12, 20'h0CCCC, MODIFIED, dat_mem[12]);
    applyStimulus(2'd3, 6'd12, 20'h0CCCC, 0, 1);

    // Reset while in UPD drops the snoop without a state write or response
    setLine(6'd13, 20'h13131, EXCLUSIVE, dat_mem[13]);
    snp_req_vld  = 1'b1;
    snp_req_op   = SUR_INV;
    snp_req_addr = {20'h13131, 6'd13, 6'd0};
    @(posedge clk);
    #1 snp_req_vld = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rst_upd_wr", st_wr_en, 1'b0);
    checkOutput("rst_upd_rsp_vld", snp_rsp_vld, 1'b0);
    checkOutput("rst_upd_lock", snp_lock_vld, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_upd_rdy", snp_req_rdy, 1'b1);
    checkOutput("rst_upd_line", st_mem[13], EXCLUSIVE);
    @(posedge clk);
    #1;

    // Randomized snoops over a small set of lines so hits and repeated updates are common
    for (int n = 0; n < 60; n++) begin
      idx = 6'($urandom_range(16, 31));
      if ($urandom_range(0, 2) == 0) setLine(idx, tag_mem[idx], 3'($urandom_range(0, 3)), dat_mem[idx]);
      tag  = ($urandom_range(0, 3) != 0) ? tag_mem[idx] : tag_mem[idx] ^ TAG_W'($urandom_range(1, 255));
      op   = 2'($urandom_range(0, 3));
      lock = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      applyStimulus(op, idx, tag, lock, int'($urandom_range(1, 3)));
    end

    repeat (3) @(negedge clk);
    checkOutput("exp_q_drained", exp_q.size(), 0);
    checkOutput("wr_q_drained", wr_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
